// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmitter slice.
package uart_pkg;

  // Parity modes.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Transmitter frame states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// A write is accepted when wr_en is high and full is low. A read is accepted
// when rd_en is high and empty is low. Both may happen in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Count is one bit wider than the pointers so DEPTH words is distinguishable from zero.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle never frees room for a write to a full FIFO.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array: written on every accepted write.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an input FIFO. Frames are sent back to back while
// the FIFO holds data; state_o exposes the frame FSM for observation.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int P_CLKFREQ   = 100_000_000,
  parameter int P_BAUDRATE  = 10_000_000,
  parameter int P_DATABITS  = 8,
  parameter int P_PARITY    = 0,
  parameter int P_STOPBITS  = 1,
  parameter int P_FIFODEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic [P_DATABITS-1:0] din_i,
  input  logic                  wr_en_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overflow_o,
  output logic                  busy_o,
  output logic                  tx_o,
  output logic                  tx_done_tick_o,
  output uart_state_e           state_o
);

  localparam int BT       = P_CLKFREQ / P_BAUDRATE;
  localparam int STOP_LEN = BT * P_STOPBITS;
  localparam int TW       = $clog2(STOP_LEN);
  localparam int BW       = $clog2(P_DATABITS);
  localparam int FW       = $clog2(P_FIFODEPTH);

  localparam logic [TW-1:0] BT_M1    = TW'(BT - 1);
  localparam logic [TW-1:0] STOP_M1  = TW'(STOP_LEN - 1);
  localparam logic [TW-1:0] STOP_M2  = TW'(STOP_LEN - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(P_DATABITS - 1);

  // Illegal parameter sets stop elaboration.
  if (P_DATABITS < 5 || P_DATABITS > 16) begin : g_bad_databits
    $error("uart_tx_fifo: P_DATABITS must be 5..16");
  end
  if (P_PARITY < PAR_NONE || P_PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_fifo: P_PARITY must be 0, 1 or 2");
  end
  if (P_STOPBITS != 1 && P_STOPBITS != 2) begin : g_bad_stopbits
    $error("uart_tx_fifo: P_STOPBITS must be 1 or 2");
  end
  if (P_FIFODEPTH < 2 || P_FIFODEPTH > 64 ||
      (P_FIFODEPTH & (P_FIFODEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: P_FIFODEPTH must be a power of two in 2..64");
  end
  if (BT < 2) begin : g_bad_bt
    $error("uart_tx_fifo: P_CLKFREQ/P_BAUDRATE must be at least 2");
  end

  uart_state_e           state;
  logic [TW-1:0]         timer;
  logic [BW-1:0]         bit_idx;
  logic [P_DATABITS-1:0] shreg;
  logic                  par_bit;
  logic [P_DATABITS-1:0] fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  fifo_has_data;
  logic [FW:0]           fifo_count;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_of(input logic [P_DATABITS-1:0] d);
    return (P_PARITY == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  assign state_o       = state;
  assign fifo_has_data = (fifo_count != '0);
  // Pop happens in IDLE, or on the last STOP cycle to chain frames with no gap.
  assign fifo_rd_en    = (state == S_IDLE) || (state == S_STOP && timer == STOP_M1);

  sync_fifo #(
    .WIDTH (P_DATABITS),
    .DEPTH (P_FIFODEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_i),
    .wr_en   (wr_en_i),
    .wr_data (din_i),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (full_o),
    .empty   (empty_o),
    .count   (fifo_count)
  );

  // Sticky overflow flag: set by any write attempted while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (wr_en_i && full_o) begin
      overflow_o <= 1'b1;
    end
  end

  // Frame FSM with registered line, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state          <= S_IDLE;
      tx_o           <= 1'b1;
      busy_o         <= 1'b0;
      tx_done_tick_o <= 1'b0;
      timer          <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      par_bit        <= 1'b0;
    end else begin
      tx_done_tick_o <= 1'b0;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (fifo_has_data) begin
            shreg   <= fifo_rd_data;
            par_bit <= parity_of(fifo_rd_data);
            state   <= S_START;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
          end else begin
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        S_START: begin
          if (timer == BT_M1) begin
            timer   <= '0;
            bit_idx <= '0;
            tx_o    <= shreg[0];
            state   <= S_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (timer == BT_M1) begin
            timer <= '0;
            if (bit_idx == LAST_BIT) begin
              if (P_PARITY != PAR_NONE) begin
                state <= S_PARITY;
                tx_o  <= par_bit;
              end else begin
                state <= S_STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx_o    <= shreg[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_PARITY: begin
          if (timer == BT_M1) begin
            timer <= '0;
            state <= S_STOP;
            tx_o  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STOP: begin
          // Done pulse is registered so it lands on the final STOP cycle.
          if (timer == STOP_M2) tx_done_tick_o <= 1'b1;
          if (timer == STOP_M1) begin
            timer <= '0;
            if (fifo_has_data) begin
              shreg   <= fifo_rd_data;
              par_bit <= parity_of(fifo_rd_data);
              state   <= S_START;
              tx_o    <= 1'b0;
            end else begin
              state  <= S_IDLE;
              tx_o   <= 1'b1;
              busy_o <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule
